// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package mc_pkg;

   typedef enum logic [2:0] {
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_JUMP,
      S_HALT
   } state_t;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_HALT   = 7'h7f;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   typedef struct packed {
      logic r;
      logic i;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic halt;
   } op_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// One-hot instruction class decode; illegal is set when no class matches.
module mc_opcode_class
   import mc_pkg::*;
(
   input  logic [6:0] op,
   output op_class_t  cls,
   output logic       illegal
);

   always_comb begin
      cls = '0;
      case (op)
         OP_R:      cls.r      = 1'b1;
         OP_I:      cls.i      = 1'b1;
         OP_LOAD:   cls.load   = 1'b1;
         OP_STORE:  cls.store  = 1'b1;
         OP_BRANCH: cls.branch = 1'b1;
         OP_JAL:    cls.jal    = 1'b1;
         OP_JALR:   cls.jalr   = 1'b1;
         OP_HALT:   cls.halt   = 1'b1;
         default:   cls        = '0;
      endcase
      illegal = ~|cls;
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Performance counters are built only when MC_PERF_CNT_EN is defined.
//
// state  | meaning
// BOOT   | post-reset, all outputs idle
// FETCH  | instruction read from memory at PC, PC+4 computed
// DECODE | op_q latched, branch/JAL target into ALUOut
// EXEC   | ALU operation for the instruction class
// MEM    | load/store data access at ALUOut
// WB     | register file write from ALUOut or MDR
// JUMP   | link register write and PC load from ALUOut
// HALT   | absorbing stop, left only by reset
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       aluop,
   output logic             reg_write,
   output logic [1:0]       mem_to_reg,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   state_t     state_q, state_d;
   logic [6:0] op_q, op_d;
   logic [6:0] op_sel;
   op_class_t  cls;
   logic       cls_illegal;

   // op_q is not yet valid in DECODE, so classify the live opcode there.
   assign op_sel = (state_q == S_DECODE) ? opcode : op_q;

   mc_opcode_class u_opcode_class (
      .op      (op_sel),
      .cls     (cls),
      .illegal (cls_illegal)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_BOOT:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = opcode;
            if (cls.jal)                      state_d = S_JUMP;
            else if (cls.halt || cls_illegal) state_d = S_HALT;
            else                              state_d = S_EXEC;
         end
         S_EXEC: begin
            if (cls.r || cls.i)             state_d = S_WB;
            else if (cls.load || cls.store) state_d = S_MEM;
            else if (cls.jalr)              state_d = S_JUMP;
            else                            state_d = S_FETCH;
         end
         S_MEM:    if (mem_ready) state_d = cls.load ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_BOOT;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_ALU;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      aluop      = ALUOP_ADD;
      reg_write  = 1'b0;
      mem_to_reg = WB_ALUOUT;
      halted     = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
         end
         S_EXEC: begin
            alu_src_a = SRC_A_RS1;
            if (cls.r) begin
               alu_src_b = SRC_B_RS2;
               aluop     = ALUOP_RTYPE;
            end else if (cls.i) begin
               alu_src_b = SRC_B_IMM;
               aluop     = ALUOP_ITYPE;
            end else if (cls.branch) begin
               alu_src_b = SRC_B_RS2;
               aluop     = ALUOP_BRANCH;
               pc_write  = branch_taken;
               pc_src    = PC_SRC_ALUOUT;
            end else begin
               alu_src_b = SRC_B_IMM;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = cls.store;
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = cls.load ? WB_MDR : WB_ALUOUT;
         end
         S_JUMP: begin
            reg_write  = 1'b1;
            mem_to_reg = WB_PC;
            pc_write   = 1'b1;
            pc_src     = PC_SRC_ALUOUT;
         end
         S_HALT: begin
            halted  = 1'b1;
            illegal = cls_illegal;
         end
         default: ;
      endcase
   end

`ifdef MC_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
   logic             retire;

   // Any return to FETCH from a state other than FETCH/BOOT ends an instruction.
   assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_BOOT);

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q;
      instret_cnt_d = instret_cnt_q;
      if (state_q != S_BOOT && state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      if (retire) instret_cnt_d = instret_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is modelled as a step string
// (F/D/X/M/W/J/H) walked once per cycle, with memory wait states inserted.
module tb_multicycle_controller;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [6:0]       opcode = '0;
   logic             branch_taken = 1'b0;
   logic             mem_ready = 1'b0;
   logic             mem_req, mem_we, iord, ir_write, pc_write;
   logic [1:0]       pc_src, alu_src_a, alu_src_b, aluop, mem_to_reg;
   logic             reg_write, halted, illegal;
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .iord         (iord),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .aluop        (aluop),
      .reg_write    (reg_write),
      .mem_to_reg   (mem_to_reg),
      .halted       (halted),
      .illegal      (illegal),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
   );

   always #5 clk = ~clk;

   logic [17:0] dut_vec;
   assign dut_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, aluop, reg_write, mem_to_reg, halted, illegal};

   int n_cmp = 0;
   int n_bad = 0;

   int fw = -1, mw = -1, fixed_bt = -1;
   logic [6:0] prog[$];
   string      cur_steps;
   logic [6:0] cur_op;
   int idx, step_cycles, waits, instr_cycles, cpi_last, retired_m, cyc_m;

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h7f};
   endfunction

   function automatic string steps_of(input logic [6:0] op);
      case (op)
         7'h33, 7'h13: return "FDXW";
         7'h03:        return "FDXMW";
         7'h23:        return "FDXM";
         7'h63:        return "FDX";
         7'h6f:        return "FDJ";
         7'h67:        return "FDXJ";
         default:      return "FDH";
      endcase
   endfunction

   function automatic logic [6:0] random_legal();
      case ($urandom_range(0, 6))
         0:       return 7'h33;
         1:       return 7'h13;
         2:       return 7'h03;
         3:       return 7'h23;
         4:       return 7'h63;
         5:       return 7'h6f;
         default: return 7'h67;
      endcase
   endfunction

   // Expected control vector for one step of an instruction.
   function automatic logic [17:0] exp_out(input byte l, input logic [6:0] op,
                                           input logic r, input logic bt);
      logic mreq, mwe, io, irw, pcw, rw, hl, il;
      logic [1:0] ps, a, b, ao, m2r;
      mreq = 0; mwe = 0; io = 0; irw = 0; pcw = 0; rw = 0; hl = 0; il = 0;
      ps = 0; a = 0; b = 0; ao = 0; m2r = 0;
      case (l)
         "F": begin mreq = 1; b = 2'b01; irw = r; pcw = r; end
         "D": begin a = 2'b01; b = 2'b10; end
         "X": begin
            a = 2'b10;
            if (op == 7'h33)      begin b = 2'b00; ao = 2'b10; end
            else if (op == 7'h13) begin b = 2'b10; ao = 2'b11; end
            else if (op == 7'h63) begin b = 2'b00; ao = 2'b01; pcw = bt; ps = 2'b01; end
            else                  b = 2'b10;
         end
         "M": begin mreq = 1; io = 1; mwe = (op == 7'h23); end
         "W": begin rw = 1; m2r = (op == 7'h03) ? 2'b01 : 2'b00; end
         "J": begin rw = 1; m2r = 2'b10; pcw = 1; ps = 2'b01; end
         "H": begin hl = 1; il = !is_legal(op); end
         default: ;
      endcase
      return {mreq, mwe, io, irw, pcw, ps, a, b, ao, rw, m2r, hl, il};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h (step %s op %h)",
                  name, $time, act, exp, cur_steps, cur_op);
      end
   endtask

   task automatic start_next();
      if (prog.size() > 0) cur_op = prog.pop_front();
      else cur_op = random_legal();
      cur_steps = steps_of(cur_op);
      idx = 0; step_cycles = 0; instr_cycles = 0;
      opcode = cur_op;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("reset_outputs", {46'd0, dut_vec}, 64'd0);
      check("reset_counters", {cycle_cnt, instret_cnt}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      cur_steps = "B"; idx = 0; step_cycles = 0; cyc_m = 0; retired_m = 0; cur_op = '0;
   endtask

   // One cycle: drive inputs, compare against the model, clock, advance the model.
   task automatic do_cycle();
      byte l;
      bit  mem_step;
      l = cur_steps[idx];
      mem_step = (l == "F") || (l == "M");
      if (mem_step && step_cycles == 0) begin
         if (l == "F") waits = (fw >= 0) ? fw : int'($urandom_range(0, 2));
         else          waits = (mw >= 0) ? mw : int'($urandom_range(0, 2));
      end
      mem_ready    = mem_step ? (step_cycles >= waits) : 1'($urandom_range(0, 1));
      branch_taken = (fixed_bt >= 0) ? fixed_bt[0] : 1'($urandom_range(0, 1));
      #2;
      check("ctrl", {46'd0, dut_vec}, {46'd0, exp_out(l, cur_op, mem_ready, branch_taken)});
`ifdef MC_PERF_CNT_EN
      check("cycle_cnt", {32'd0, cycle_cnt}, {32'd0, 32'(cyc_m)});
      check("instret_cnt", {32'd0, instret_cnt}, {32'd0, 32'(retired_m)});
`else
      check("counters_tied", {cycle_cnt, instret_cnt}, 64'd0);
`endif
      @(posedge clk);
      #1;
      if (l != "B" && l != "H") begin cyc_m++; instr_cycles++; end
      if (mem_step && !mem_ready) step_cycles++;
      else if (l != "H") begin
         step_cycles = 0;
         idx++;
         if (idx == cur_steps.len()) begin
            if (l != "B") begin retired_m++; cpi_last = instr_cycles; end
            start_next();
         end
      end
   endtask

   task automatic run_until(input byte tgt, input int maxc, input string name);
      int n = 0;
      while (cur_steps[idx] != tgt && n < maxc) begin do_cycle(); n++; end
      n_cmp++;
      if (cur_steps[idx] != tgt) begin
         n_bad++;
         $display("FAIL %s: timeout after %0d cycles, step %s idx %0d", name, n, cur_steps, idx);
      end
   endtask

   task automatic run_instrs(input int k, input int maxc, input string name);
      int tgt = retired_m + k;
      int n = 0;
      while (retired_m < tgt && n < maxc) begin do_cycle(); n++; end
      n_cmp++;
      if (retired_m < tgt) begin
         n_bad++;
         $display("FAIL %s: timeout after %0d cycles, retired %0d of %0d", name, n, retired_m, tgt);
      end
   endtask

   initial begin
      logic [6:0] op;
      apply_reset();

      // Directed instruction sequence with literal CPI pins.
      fw = 0; mw = 0; fixed_bt = 0;
      prog = '{7'h33, 7'h03, 7'h63, 7'h63, 7'h6f, 7'h67, 7'h23, 7'h13};
      run_instrs(1, 20, "add_run");  check("add_cpi", 64'(cpi_last), 64'd4);
      mw = 2;
      run_instrs(1, 20, "lw_run");   check("lw_wait_cpi", 64'(cpi_last), 64'd7);
      mw = 0; fixed_bt = 1;
      run_instrs(1, 20, "beq_t_run"); check("beq_taken_cpi", 64'(cpi_last), 64'd3);
      fixed_bt = 0;
      run_instrs(1, 20, "beq_n_run"); check("beq_not_cpi", 64'(cpi_last), 64'd3);
      run_instrs(1, 20, "jal_run");  check("jal_cpi", 64'(cpi_last), 64'd3);
      run_instrs(1, 20, "jalr_run"); check("jalr_cpi", 64'(cpi_last), 64'd4);
      run_instrs(1, 20, "sw_run");   check("sw_cpi", 64'(cpi_last), 64'd4);
      run_instrs(1, 20, "addi_run"); check("addi_cpi", 64'(cpi_last), 64'd4);

      // Halt is sticky.
      prog = '{7'h7f};
      run_until("H", 30, "halt_reach");
      repeat (100) do_cycle();
      check("halt_sticky", {62'd0, halted, illegal}, 64'd2);

      // Unsupported opcode.
      apply_reset();
      prog = '{7'h00};
      run_until("H", 30, "illegal_reach");
      repeat (3) do_cycle();
      check("illegal_halt", {62'd0, halted, illegal}, 64'd3);

      // Asynchronous reset in the middle of a store's MEM phase.
      apply_reset();
      mw = 5;
      prog = '{7'h23};
      run_until("M", 30, "store_mem_reach");
      do_cycle();
      check("store_mem_we", {61'd0, mem_req, mem_we, iord}, 64'd7);
      apply_reset();
      do_cycle();
      do_cycle();

      // Counters over three instructions then a halt.
      apply_reset();
      fw = 0; mw = 0; fixed_bt = 0;
      prog = '{7'h33, 7'h23, 7'h63, 7'h7f};
      run_until("H", 40, "cnt_reach");
      repeat (5) do_cycle();
`ifdef MC_PERF_CNT_EN
      check("cnt_cycle_total", {32'd0, cycle_cnt}, 64'd13);
      check("cnt_instret_total", {32'd0, instret_cnt}, 64'd3);
`else
      check("cnt_absent", {cycle_cnt, instret_cnt}, 64'd0);
`endif

      // Randomized programs with random wait states and branch outcomes.
      fw = -1; mw = -1; fixed_bt = -1;
      repeat (6) begin
         apply_reset();
         prog.delete();
         repeat (20) prog.push_back(random_legal());
         if ($urandom_range(0, 1) == 1) prog.push_back(7'h7f);
         else begin
            op = 7'($urandom_range(0, 127));
            while (is_legal(op)) op = 7'($urandom_range(0, 127));
            prog.push_back(op);
         end
         run_until("H", 600, "random_reach_halt");
         repeat (3) do_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I datapath in this codebase. It replaces single-cycle control by stepping each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a ready handshake to a shared single-port instruction/data memory. It drives every datapath mux select, write enable and ALU op class, and halts on the 0x7f halt opcode or on an unsupported opcode.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction bits [6:0] from the instruction register; valid from DECODE onward.
- branch_taken  in  1  branch comparison result from the ALU; valid in EXEC of a B-type instruction.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory request.
- mem_we  out  1  write when high, read when low.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and MDR from memory read data.
- pc_write  out  1  load the PC.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut.
- alu_src_a  out  2  ALU A operand: 00 = PC, 01 = old_pc, 10 = rs1.
- alu_src_b  out  2  ALU B operand: 00 = rs2, 01 = constant 4, 10 = imm.
- aluop  out  2  to alu_control: 00 = add, 01 = branch compare, 10 = R-type, 11 = I-type.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC.
- halted  out  1  sticky halt indication.
- illegal  out  1  sticky flag: the halt was caused by an unsupported opcode.
- cycle_cnt  out  CNT_W  cycle counter (see Configuration).
- instret_cnt  out  CNT_W  retired-instruction counter (see Configuration).

## Operation
- Moore machine. Every control output is decoded from the state register and a copy of `opcode` latched at the end of DECODE (`op_q`). The only exceptions are the FETCH and MEM outputs that are qualified by `mem_ready`, and `pc_write` in EXEC of a branch, which is qualified by `branch_taken`.
- Any output not listed for a state is 0.
- BOOT: reset state. All outputs are 0. Next state is FETCH.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, and the machine goes to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=01, alu_src_b=10, aluop=00 (branch/JAL target goes into ALUOut). Latch op_q. Next state by opcode:
  - 0x33, 0x13, 0x03, 0x23, 0x63, 0x67 → EXEC.
  - 0x6f → JUMP.
  - 0x7f → HALT.
  - Any other opcode → HALT with illegal set to 1.
- EXEC:
  - R-type: a=10, b=00, aluop=10 → WB.
  - I-type: a=10, b=10, aluop=11 → WB.
  - Load/store: a=10, b=10, aluop=00 → MEM.
  - Branch: a=10, b=00, aluop=01; pc_write=branch_taken, pc_src=01 → FETCH.
  - JALR: a=10, b=10, aluop=00 → JUMP.
- MEM: mem_req=1, iord=1, mem_we=1 for a store. Stays in MEM until mem_ready=1. On mem_ready: a load goes to WB, a store goes to FETCH.
- WB: reg_write=1, mem_to_reg=01 for a load and 00 otherwise → FETCH.
- JUMP: reg_write=1, mem_to_reg=10, pc_write=1, pc_src=01 → FETCH. The register file and the PC both capture on the same edge, so the return address written is PC+4.
- HALT: halted=1, every other output 0. HALT is absorbing; only reset leaves it.
- Handshake rules:
  - mem_req, mem_we and iord stay stable from assertion until the cycle in which mem_ready is sampled high.
  - mem_ready is ignored when mem_req=0.
  - mem_ready may already be high in the first request cycle, giving a zero-wait access.

## Timing
- Cycles per instruction with zero-wait memory: branch 3, JAL 3, R/I 4, store 4, JALR 4, load 5. Each cycle mem_ready is held low in FETCH or MEM adds one cycle.
- Reset is asynchronous. The state goes to BOOT immediately, so every output, including halted and illegal, drops to 0 without waiting for an edge. This also applies mid-transaction; the memory must tolerate a withdrawn mem_req.
- After reset deasserts, the first edge enters FETCH.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_cnt increments on every edge where the state is neither BOOT nor HALT.
  - instret_cnt increments on every edge that leaves an instruction's final state back to FETCH.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- MC_PERF_CNT_EN not defined: both ports still exist and are tied to 0. No counter flops are built.

## Structure
- Package mc_pkg holds:
  - the state enum (BOOT, FETCH, DECODE, EXEC, MEM, WB, JUMP, HALT);
  - the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_HALT);
  - the pc_src, alu_src_a, alu_src_b, aluop and mem_to_reg encodings.
- Sub-module mc_opcode_class: combinational decode of op_q into a one-hot instruction class plus an illegal bit. It is used by both the next-state logic and the output logic.

## Test plan
- add x3,x1,x2 (0x33), mem_ready always 1 → states BOOT,FETCH,DECODE,EXEC,WB; reg_write=1 only in WB with mem_to_reg=00; next fetch 4 cycles after the first.
- lw (0x03) with mem_ready held low for 2 cycles in MEM → mem_req=1, iord=1, mem_we=0 stable for 3 cycles; WB with mem_to_reg=01; CPI 7.
- beq (0x63):
  - branch_taken=1 → pc_write=1, pc_src=01 in EXEC; FETCH follows.
  - branch_taken=0 → pc_write=0 in EXEC.
- jal (0x6f) → JUMP directly after DECODE with reg_write=1, mem_to_reg=10, pc_write=1. Opcode 0x7f → halted=1, illegal=0, sticky for 100 cycles. Opcode 0x00 → halted=1, illegal=1.
- rst pulsed asynchronously while in MEM of a store (mem_we=1) → all outputs 0 in the same cycle; after release: BOOT, then FETCH.
- With MC_PERF_CNT_EN: run 3 instructions, then halt → instret_cnt=3 and cycle_cnt equals the sum of the CPIs plus the halt's FETCH and DECODE; both counters frozen while halted. Without the macro, both counters read 0.
